// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit blocks.
// UART_TX_PARITY_EN selects the 11-bit even-parity transmit frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 217;
  localparam int DATA_BITS        = 8;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered pointers and a count one bit wider
// than the pointers; DEPTH must be a power of two.
module byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DATA_W-1:0]      i_data,
  output logic [DATA_W-1:0]      o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/uart_echo_tx.sv
// Buffers received bytes and re-sends each one as an 8N1 UART frame, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_echo_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_rx_dv,
  input  logic [7:0]                  i_rx_byte,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              baud_tick, pop, tx_line;
  logic [7:0]        fifo_head;
  logic              fifo_full, fifo_empty;

  byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_rx_dv),
    .i_pop   (pop),
    .i_data  (i_rx_byte),
    .o_head  (fifo_head),
    .o_count (o_fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign baud_tick = (baud_q == BAUD_LAST);
  assign ovf_d     = ovf_q | (i_rx_dv & fifo_full & ~pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    tx_line = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) baud_d = baud_tick ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          bit_d   = '0;
          baud_d  = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
          state_d = START;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        tx_line = shift_q[0];
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = PARITY;
`else
          if (bit_q == BIT_LAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_line = parity_q;
        if (baud_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame payload needs no reset: it is only observed outside IDLE.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign o_tx_serial = tx_line;
  assign o_tx_active = (state_q != IDLE);
  assign o_tx_done   = done_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_echo_tx.sv
// Self-checking bench for uart_echo_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_echo_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_serial, tx_active, tx_done, overflow;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_echo_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_dv      (rx_dv),
    .i_rx_byte    (rx_byte),
    .o_tx_serial  (tx_serial),
    .o_tx_active  (tx_active),
    .o_tx_done    (tx_done),
    .o_fifo_count (fifo_count),
    .o_overflow   (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue plus position within the current frame.
  logic [7:0]  mq[$];
  int          fcyc;
  logic [10:0] fbits;
  logic        m_done, m_ovf;

  int   done_cnt, act_cnt, peak;
  logic cap [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic model_reset();
    mq.delete();
    fcyc   = -1;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] b);
    logic pop, acc;
    pop    = (fcyc < 0) && (mq.size() > 0);
    acc    = dv && ((mq.size() < DEPTH) || pop);
    m_done = 1'b0;
    if (dv && !acc) m_ovf = 1'b1;
    if (pop) begin
      fbits = frame_of(mq.pop_front());
      fcyc  = 0;
    end else if (fcyc >= 0) begin
      fcyc++;
      if (fcyc == FRAME_CYC) begin
        fcyc   = -1;
        m_done = 1'b1;
      end
    end
    if (acc) mq.push_back(b);
  endtask

  task automatic compare_all();
    logic exp_line;
    exp_line = (fcyc < 0) ? 1'b1 : fbits[fcyc / CPB];
    check("tx_serial",  tx_serial,  exp_line);
    check("tx_active",  tx_active,  fcyc >= 0);
    check("tx_done",    tx_done,    m_done);
    check("fifo_count", fifo_count, mq.size());
    check("overflow",   overflow,   m_ovf);
  endtask

  task automatic clr_stats();
    done_cnt = 0;
    act_cnt  = 0;
    peak     = 0;
  endtask

  task automatic tick(input logic dv, input logic [7:0] b);
    @(negedge clk);
    rx_dv   = dv;
    rx_byte = b;
    @(posedge clk);
    if (rst_n) model_edge(dv, b);
    #1;
    compare_all();
    done_cnt += int'(tx_done);
    act_cnt  += int'(tx_active);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  initial begin
    logic [8:0] a5_seq;
    int         guard;
    a5_seq  = 9'b101001010;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    clr_stats();
    repeat (100) tick(1'b0, 8'h00);
    check("t1_active_cycles", act_cnt, 0);
    check("t1_done_pulses", done_cnt, 0);

    // Single 0xA5 frame
    clr_stats();
    tick(1'b1, 8'hA5);
    cap[0] = tx_serial;
    for (int i = 1; i <= FRAME_CYC + 3; i++) begin
      tick(1'b0, 8'h00);
      cap[i] = tx_serial;
    end
    check("t2_idle_before_start", cap[0], 1'b1);
    for (int k = 0; k < 9; k++) begin
      check("t2_bit_first_cycle", cap[1 + 4*k], a5_seq[k]);
      check("t2_bit_last_cycle",  cap[4 + 4*k], a5_seq[k]);
    end
    check("t2_done_pulses", done_cnt, 1);
    check("t2_active_cycles", act_cnt, FRAME_CYC);
    check("t2_count_end", fifo_count, 0);

    // Three back-to-back bytes
    clr_stats();
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h03);
    repeat (3 * FRAME_CYC + 10) tick(1'b0, 8'h00);
    check("t3_peak_count", peak, 2);
    check("t3_done_pulses", done_cnt, 3);

    // Overflow while a frame is active
    clr_stats();
    tick(1'b1, 8'h11);
    repeat (3) tick(1'b0, 8'h00);
    check("t4_busy", tx_active, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h20 + 8'(i));
    check("t4_count_full", fifo_count, 4);
    check("t4_overflow_set", overflow, 1'b1);
    repeat (5 * FRAME_CYC + 10) tick(1'b0, 8'h00);
    check("t4_done_pulses", done_cnt, 5);
    check("t4_overflow_sticky", overflow, 1'b1);

    // Reset during data bit 3
    tick(1'b1, 8'h5A);
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'hC3);
    guard = 0;
    while (fcyc != 4 * CPB + 1 && guard < 200) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check("t5_reached_bit3", guard < 200, 1'b1);
    check("t5_active_before", tx_active, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_line_in_reset", tx_serial, 1'b1);
    check("t5_count_in_reset", fifo_count, 0);
    check("t5_active_in_reset", tx_active, 1'b0);
    check("t5_overflow_cleared", overflow, 1'b0);
    model_reset();
    repeat (2) tick(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    clr_stats();
    repeat (60) tick(1'b0, 8'h00);
    check("t5_no_resume", act_cnt, 0);
    tick(1'b1, 8'h81);
    repeat (FRAME_CYC + 4) tick(1'b0, 8'h00);
    check("t5_new_frame_done", done_cnt, 1);

    // 0x07: data ends in 0, then parity (if enabled) and stop
    clr_stats();
    tick(1'b1, 8'h07);
    cap[0] = tx_serial;
    for (int i = 1; i <= FRAME_CYC + 3; i++) begin
      tick(1'b0, 8'h00);
      cap[i] = tx_serial;
    end
    check("t6_d7", cap[1 + 4*8 + 1], 1'b0);
    check("t6_frame_cycles", act_cnt, FRAME_CYC);
`ifdef UART_TX_PARITY_EN
    check("t6_parity_bit", cap[1 + 4*9 + 1], 1'b1);
    check("t6_stop_bit", cap[1 + 4*10 + 1], 1'b1);
    check("t6_frame_44", act_cnt, 44);
`else
    check("t6_stop_bit", cap[1 + 4*9 + 1], 1'b1);
`endif

    // Random traffic: sparse then dense
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 39) == 0, 8'($urandom));
    for (int i = 0; i < 1000; i++)
      tick($urandom_range(0, 3) == 0, 8'($urandom));
    repeat (5 * FRAME_CYC + 10) tick(1'b0, 8'h00);
    check("rand_drained", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
